// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
// Bundles the host write port and the UART transmit handshake of the
// transmit FIFO. The FIFO itself connects through the slave modport. The
// surrounding logic (host plus UART transmitter) connects through master.
//
//   wr_en    host -> fifo   write strobe, one byte per high cycle
//   wr_data  host -> fifo   byte to store
//   clr_ovf  host -> fifo   clears the sticky overflow flag
//   tx_done  uart -> fifo   completion pulse from the transmitter
//   tx_data  fifo -> uart   byte for the transmitter (registered)
//   tx_start fifo -> uart   one-cycle start pulse (registered)
//   count    fifo -> host   bytes currently stored, 0..2^AW
//   full     fifo -> host   count == 2^AW
//   empty    fifo -> host   count == 0
//   busy     fifo -> host   a byte is being started or is in flight
//   overflow fifo -> host   sticky, set by a write attempted while full
interface uart_tx_fifo_if #(
  parameter int D_W = 8,
  parameter int AW  = 4
);
  logic           wr_en;
  logic [D_W-1:0] wr_data;
  logic           clr_ovf;
  logic           tx_done;
  logic [D_W-1:0] tx_data;
  logic           tx_start;
  logic [AW:0]    count;
  logic           full;
  logic           empty;
  logic           busy;
  logic           overflow;

  modport master (
    output wr_en, wr_data, clr_ovf, tx_done,
    input  tx_data, tx_start, count, full, empty, busy, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, tx_done,
    output tx_data, tx_start, count, full, empty, busy, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit-side byte buffer between the host and the UART transmitter. The
// host writes bytes with a single-cycle strobe. The FIFO stores up to 2^AW
// of them and hands them one at a time to the UART using the
// tx_data / tx_start / tx_done handshake.
//
// Ports:
//   clk  system clock (the same clock that drives the UART)
//   rst  synchronous active-high reset
//   bus  uart_tx_fifo_if.slave: write port, status flags and UART handshake
module uart_tx_fifo #(
  parameter int D_W = 8,
  parameter int AW  = 4
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Storage and control state
  logic [D_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [D_W-1:0] tx_data_q, tx_data_d;
  logic           tx_start_q, tx_start_d;
  logic           overflow_q, overflow_d;
  state_t         state_q, state_d;

  logic full_w;
  logic empty_w;
  logic wr_acc;
  logic wr_rej;
  logic pop;

  // Flags come from the registered count only. A pop on the same edge
  // therefore cannot make room for a write that arrives while full.
  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);
  assign wr_acc  = bus.wr_en && !full_w;
  assign wr_rej  = bus.wr_en &&  full_w;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!empty_w)   state_d = ST_START;
      ST_START:                 state_d = ST_WAIT;
      ST_WAIT:  if (bus.tx_done) state_d = ST_WAIT == ST_WAIT ? ST_IDLE : ST_WAIT;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM: output logic. A pop happens only when leaving IDLE. The start
  // pulse is registered, so it is high during the START cycle.
  always_comb begin
    pop        = (state_q == ST_IDLE) && !empty_w;
    tx_start_d = pop;
    tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
  end

  // Pointer, count and overflow next-state
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A rejected write wins over a clear on the same edge.
    overflow_d = overflow_q;
    if (bus.clr_ovf) overflow_d = 1'b0;
    if (wr_rej)      overflow_d = 1'b1;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage. It is not reset: the pointers and count define which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.count    = count_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic model_done = 1'b0;
  logic man_done = 1'b0;
  logic auto_uart = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int starts_seen = 0;
  int timer = 0;
  logic [7:0] rx_q [$];

  uart_tx_fifo_if #(.D_W(8), .AW(4)) bus ();

  assign bus.tx_done = model_done | man_done;

  uart_tx_fifo #(.D_W(8), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // UART transmitter model. It samples on the falling edge. It logs every
  // start pulse together with its byte. When auto_uart is set, it returns
  // tx_done 10 cycles after each start.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (bus.tx_start) begin
      starts_seen = starts_seen + 1;
      rx_q.push_back(bus.tx_data);
    end
    if (rst) begin
      timer = 0;
    end else if (auto_uart) begin
      if (timer > 0) begin
        timer = timer - 1;
        if (timer == 0) model_done = 1'b1;
      end
      if (bus.tx_start) timer = 10;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.clr_ovf = 1'b0;
    man_done = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tx_data"},  32'(bus.tx_data),  32'h00);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 32'h0);
    check({tag, "_count"},    32'(bus.count),    32'h0);
    check({tag, "_full"},     32'(bus.full),     32'h0);
    check({tag, "_empty"},    32'(bus.empty),    32'h1);
    check({tag, "_busy"},     32'(bus.busy),     32'h0);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'h0);
  endtask

  // Write n consecutive bytes, first, first+1, ...; one per cycle.
  task automatic write_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = first + 8'(i);
      cyc(1);
    end
    bus.wr_en = 1'b0;
  endtask

  // Wait (bounded) until the given number of starts has been seen and the FIFO is drained.
  task automatic wait_drained(input string tag, input int target, input int limit);
    int k;
    k = 0;
    while (!(starts_seen >= target && !bus.busy && bus.empty) && k < limit) begin
      cyc(1);
      k++;
    end
    check({tag, "_timeout"}, 32'(k < limit), 32'h1);
  endtask

  initial begin
    int s0;
    int rxb;
    logic [7:0] exp_b;

    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;

    // Reset, then idle with a stray tx_done
    do_reset();
    check_reset_state("rst");
    s0 = starts_seen;
    for (int i = 0; i < 20; i++) begin
      man_done = (i == 5);
      cyc(1);
    end
    man_done = 1'b0;
    check("idle_starts", 32'(starts_seen - s0), 32'd0);
    check("idle_busy",   32'(bus.busy),  32'h0);
    check("idle_count",  32'(bus.count), 32'h0);
    check("idle_empty",  32'(bus.empty), 32'h1);

    // Single byte 0xA5
    s0 = starts_seen;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    cyc(1);                                   // E0
    bus.wr_en = 1'b0;
    check("single_e0_count", 32'(bus.count),    32'd1);
    check("single_e0_start", 32'(bus.tx_start), 32'h0);
    cyc(1);                                   // E1: pop
    check("single_e1_start", 32'(bus.tx_start), 32'h1);
    check("single_e1_data",  32'(bus.tx_data),  32'hA5);
    check("single_e1_busy",  32'(bus.busy),     32'h1);
    check("single_e1_count", 32'(bus.count),    32'd0);
    cyc(1);                                   // E2
    check("single_e2_start", 32'(bus.tx_start), 32'h0);
    check("single_e2_busy",  32'(bus.busy),     32'h1);
    cyc(3);
    check("single_wait_data", 32'(bus.tx_data), 32'hA5);
    check("single_wait_busy", 32'(bus.busy),    32'h1);
    man_done = 1'b1;
    cyc(1);
    man_done = 1'b0;
    check("single_done_busy", 32'(bus.busy), 32'h0);
    cyc(3);
    check("single_starts", 32'(starts_seen - s0), 32'd1);

    // Burst. A priming byte is held in WAIT so that the 16 burst bytes fill the FIFO.
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h00;
    cyc(1);
    bus.wr_en = 1'b0;
    cyc(2);
    rxb = rx_q.size();
    s0 = starts_seen;
    write_seq(8'h01, 16);
    check("burst_count", 32'(bus.count), 32'd16);
    check("burst_full",  32'(bus.full),  32'h1);
    check("burst_ovf0",  32'(bus.overflow), 32'h0);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hFF;
    cyc(1);
    bus.wr_en = 1'b0;
    check("burst_ovf1",      32'(bus.overflow), 32'h1);
    check("burst_cnt_after", 32'(bus.count),    32'd16);
    man_done = 1'b1;
    cyc(1);
    man_done = 1'b0;
    auto_uart = 1'b1;
    wait_drained("burst", s0 + 16, 600);
    cyc(20);
    check("burst_starts", 32'(starts_seen - s0), 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'(i + 1);
      check($sformatf("burst_byte%0d", i), 32'(rx_q[rxb + i]), 32'(exp_b));
    end
    bus.clr_ovf = 1'b1;
    cyc(1);
    bus.clr_ovf = 1'b0;
    check("burst_clr_ovf", 32'(bus.overflow), 32'h0);

    // Wrap-around: 12 bytes, drain 8, 10 more
    do_reset();
    auto_uart = 1'b1;
    rxb = rx_q.size();
    s0 = starts_seen;
    write_seq(8'h20, 12);
    begin
      int k;
      k = 0;
      while (starts_seen - s0 < 8 && k < 300) begin
        cyc(1);
        k++;
      end
      check("wrap_drain8_timeout", 32'(k < 300), 32'h1);
    end
    write_seq(8'h30, 10);
    wait_drained("wrap", s0 + 22, 600);
    check("wrap_starts", 32'(starts_seen - s0), 32'd22);
    for (int i = 0; i < 22; i++) begin
      exp_b = (i < 12) ? 8'(8'h20 + i) : 8'(8'h30 + i - 12);
      check($sformatf("wrap_byte%0d", i), 32'(rx_q[rxb + i]), 32'(exp_b));
    end
    check("wrap_ovf", 32'(bus.overflow), 32'h0);
    auto_uart = 1'b0;

    // Simultaneous write and pop
    do_reset();
    write_seq(8'h50, 4);                      // 0x50 in flight, three bytes queued
    check("sim_q3_count", 32'(bus.count),   32'd3);
    check("sim_q3_data",  32'(bus.tx_data), 32'h50);
    man_done = 1'b1;
    cyc(1);                                   // WAIT -> IDLE
    man_done = 1'b0;
    check("sim_idle_busy",  32'(bus.busy),  32'h0);
    check("sim_idle_count", 32'(bus.count), 32'd3);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h54;
    cyc(1);                                   // pop and write together
    check("sim_pop_count", 32'(bus.count),    32'd3);
    check("sim_pop_start", 32'(bus.tx_start), 32'h1);
    check("sim_pop_data",  32'(bus.tx_data),  32'h51);
    write_seq(8'h55, 13);
    check("sim_full_count", 32'(bus.count), 32'd16);
    check("sim_full_flag",  32'(bus.full),  32'h1);
    man_done = 1'b1;
    cyc(1);
    man_done = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h62;
    cyc(1);                                   // pop while full, write rejected
    check("simf_ovf",   32'(bus.overflow), 32'h1);
    check("simf_count", 32'(bus.count),    32'd15);
    check("simf_full",  32'(bus.full),     32'h0);
    check("simf_data",  32'(bus.tx_data),  32'h52);
    cyc(1);                                   // 0x62 now accepted
    check("simf_refill", 32'(bus.count), 32'd16);
    bus.wr_data = 8'h63;
    bus.clr_ovf = 1'b1;
    cyc(1);                                   // reject and clear on the same edge
    check("simf_setwins", 32'(bus.overflow), 32'h1);
    bus.wr_en = 1'b0;
    cyc(1);
    bus.clr_ovf = 1'b0;
    check("simf_cleared", 32'(bus.overflow), 32'h0);
    check("simf_count16", 32'(bus.count),    32'd16);

    // Reset during WAIT with five bytes queued
    do_reset();
    write_seq(8'h70, 6);
    check("rstw_busy",  32'(bus.busy),    32'h1);
    check("rstw_count", 32'(bus.count),   32'd5);
    check("rstw_data",  32'(bus.tx_data), 32'h70);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_reset_state("rstw");
    s0 = starts_seen;
    man_done = 1'b1;
    cyc(1);
    man_done = 1'b0;
    cyc(5);
    check("rstw_starts", 32'(starts_seen - s0), 32'd0);
    check("rstw_busy2",  32'(bus.busy),  32'h0);
    check("rstw_count2", 32'(bus.count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer between the host logic and the UART top's transmit port. Accepts bytes through a single-cycle write strobe, stores up to 2^AW of them, and drains them one at a time into the UART transmitter through its `input_data` / `tx_start` / `tx_done` handshake. This lets the host burst bytes without waiting out each character time.

## Interface
- `D_W`, default 8: data width in bits; must match the UART's `D_W`.
- `AW`, default 4: address width; FIFO depth is 2^AW, so 16 entries by default.

- `clk`  in  1: system clock, the same clock that drives the UART top.
- `rst`  in  1: reset, synchronous and active-high.
- `wr_en`  in  1: host write strobe; one byte per cycle in which it is high.
- `wr_data`  in  D_W: byte written when `wr_en` is high and `full` is low.
- `clr_ovf`  in  1: clears the sticky `overflow` flag.
- `tx_done`  in  1: completion pulse from the UART transmitter.
- `tx_data`  out  D_W: byte presented to the UART's `input_data`; registered.
- `tx_start`  out  1: one-cycle start pulse to the UART; registered.
- `count`  out  AW+1: number of bytes currently stored, range 0..2^AW.
- `full`  out  1: high when `count` = 2^AW.
- `empty`  out  1: high when `count` = 0.
- `busy`  out  1: high while the FSM is in START or WAIT.
- `overflow`  out  1: sticky flag, set by any write attempted while `full` is high.

## Operation
- Storage: 2^AW × D_W memory; `wr_ptr` and `rd_ptr` are each AW bits wide and wrap modulo 2^AW; `count` is a separate AW+1-bit register.
- Write: a write is accepted when `wr_en` && !`full` at a clock edge. On acceptance, `mem[wr_ptr]` ← `wr_data` and `wr_ptr`++.
- Full rejection: `full` is computed from the registered `count`. A write in a cycle where `full` is high is dropped and sets `overflow`, even if a pop happens on the same edge.
- Pop: a pop occurs only on the IDLE→START transition. It loads `tx_data` ← `mem[rd_ptr]`, then `rd_ptr`++.
- Count update per edge: accepted write only → +1; pop only → −1; both on the same edge → unchanged.
- FSM states:
  - IDLE: if `count` ≠ 0, pop and go to START; otherwise stay in IDLE.
  - START: `tx_start` = 1 for exactly this one cycle; go to WAIT unconditionally.
  - WAIT: hold `tx_data` stable; on `tx_done` = 1, go to IDLE; otherwise stay in WAIT.
- `tx_done` in IDLE or START: ignored.
- `overflow`:
  - Set by a rejected write; `clr_ovf` clears it.
  - If a rejected write and `clr_ovf` occur on the same edge, set wins.
- Reset mid-operation:
  - All pointers, `count`, the FSM state and every output return to their reset values.
  - Any queued bytes and the byte in flight are discarded.
  - A `tx_done` arriving after reset is ignored, because the FSM is in IDLE.

## Timing
- Reset values: `tx_data` = 0, `tx_start` = 0, `count` = 0, `full` = 0, `empty` = 1, `busy` = 0, `overflow` = 0, FSM state IDLE, both pointers 0.
- Write-to-start latency into an empty, idle FIFO:
  - Write accepted at edge E0.
  - `count` = 1 after E0.
  - Pop at E1; `tx_start` and the new `tx_data` are valid in the cycle after E1.
  - `tx_start` falls at E2.
- Back-to-back bytes: `tx_done` sampled at edge Ed → IDLE; next pop at Ed+1. Minimum gap is 2 cycles from the `tx_done` edge to the next `tx_start`.
- `tx_data` changes only on a pop; it is stable from START through the end of WAIT.
- `full`, `empty` and `count` are valid the cycle after the edge that changes them.
- Throughput: at most one byte per UART character time.

## Test plan
- Reset, then idle: `count` = 0, `empty` = 1, `tx_start` stays 0 for 20 cycles, with a `tx_done` pulse injected during them. FSM must remain IDLE.
- Single byte: write 0xA5 at E0 → `tx_start` high for exactly one cycle after E1 with `tx_data` = 0xA5; `busy` = 1 until `tx_done`; `count` returns to 0.
- Burst: write 0x01..0x10 in 16 consecutive cycles → `full` = 1 after the 16th write; a 17th write of 0xFF sets `overflow` and is never transmitted. A bench UART model pulsing `tx_done` 10 cycles after each `tx_start` receives 0x01..0x10 in order, 16 `tx_start` pulses in total.
- Wrap-around: write 12 bytes, drain 8, write 10 more → pointers wrap past index 15; all 22 bytes emerge in write order.
- Simultaneous write and pop: with `count` = 3 in IDLE, write at the pop edge → `count` stays 3; with `count` = 16, a write on the pop edge is rejected and `overflow` = 1. A subsequent `clr_ovf` clears `overflow`.
- Reset during WAIT: assert `rst` with 5 bytes queued and one byte in flight → all outputs return to reset values; a later `tx_done` pulse produces no `tx_start`.
